mul4su_share_arb: RTL and testbench
===================================

# mul4su_share_arb

Round-robin arbiter and two-stage pipeline that shares one 4x4 signed×unsigned exact multiplier core among up to NREQ requesters. Each requester presents a 4-bit signed operand and a 4-bit unsigned operand on a valid/ready port. The block returns the 8-bit signed product, tagged with the requester index, on a single shared response port that honours backpressure. It sits between the multiplier datapath and its client units.

## Interface
- NREQ, default 4: number of requesters; legal range 2..8.
- IDW, default 2: width of the response tag; equals ceil(log2(NREQ)).
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_s  in  4*NREQ  signed operand; requester i uses bits [4i+3:4i]
- req_u  in  4*NREQ  unsigned operand; requester i uses bits [4i+3:4i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns rsp_prod
- rsp_prod  out  8  signed product s×u, two's complement
- busy  out  1  high when any stage holds a valid entry

## Operation
- Stage A (issue register): op_s, op_u, op_id, a_valid. Stage B (response register): rsp_prod, rsp_id, rsp_valid.
- b_ready = !rsp_valid | rsp_ready. a_ready = !a_valid | b_ready.
- Arbitration is combinational from req_valid, ptr and a_ready:
  - When a_ready=1, search requesters in order ptr, ptr+1, …, NREQ-1, 0, … for the first i with req_valid[i]=1.
  - Drive req_ready[i]=1 for that i and 0 for all others.
  - When a_ready=0, or no request is valid, req_ready is all zero.
- Transfer occurs when req_valid[i] & req_ready[i] are both high.
  - On a transfer: op_s←req_s[i], op_u←req_u[i], op_id←i, a_valid←1, ptr←(i+1) mod NREQ.
  - With no transfer and b_ready=1, a_valid←0.
  - ptr changes only on a transfer.
- The core computes the product combinationally from op_s and op_u.
- When a_valid & b_ready: rsp_prod←product, rsp_id←op_id, rsp_valid←1.
- When rsp_valid & rsp_ready and no new entry is loaded, rsp_valid←0.
- Stalled stages hold all registers unchanged.
- Requesters hold req_valid and their operands stable until accepted. Dropping an unaccepted request is legal and has no effect.
- Arithmetic:
  - Product = signed(s)×unsigned(u), in the range -120..+105. It always fits in 8 bits; no saturation or overflow path exists.
  - Examples: s=4'h8 (-8), u=15 → 8'h88; s=4'h7, u=15 → 8'h69; s=4'hF (-1), u=1 → 8'hFF.
- busy = a_valid | rsp_valid.

## Timing
- Reset values: ptr=0, a_valid=0, op_s/op_u/op_id=0, rsp_valid=0, rsp_prod=8'h00, rsp_id=0, busy=0. req_ready is 0 during the reset cycle.
- Reset mid-operation discards both pipeline entries; their responses are never produced. The first grant after reset uses ptr=0.
- Latency: a request accepted at edge E0 appears with rsp_valid=1 after edge E1 if rsp_ready stays high. Latency is 2 cycles from the request-valid cycle to the response-valid cycle.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Backpressure:
  - rsp_ready=0 with rsp_valid=1 freezes stage B.
  - Stage A accepts one more request and then freezes.
  - req_ready goes all zero on the cycle both stages are full.
  - Nothing is lost or duplicated.
- When rsp_ready rises with both stages full, B takes A's entry and A accepts a new grant on the same edge.
- Starvation bound: a continuously valid requester is granted within NREQ transfers.
- Responses leave in acceptance order; rsp_id disambiguates the owner.

## Test plan
- Reset, then req_valid=4'b0001, s=7, u=15 → req_ready=4'b0001; two cycles later rsp_valid=1, rsp_prod=8'h69, rsp_id=0; busy falls after consume.
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0,…; one response per cycle with matching rsp_id.
- Exhaustive sweep of all 256 (s,u) pairs through requester 2 → rsp_prod equals the signed×unsigned product for each; s=8,u=15 gives 8'h88, s=15,u=1 gives 8'hFF.
- rsp_ready held 0 for 5 cycles under full load → exactly 2 entries are accepted, then req_ready=0; after release, responses appear in order with no loss or duplication.
- Requester 1 granted last, then requesters 0 and 3 both valid → requester 3 is granted first (ptr=2 wraps to 3 before 0).
- Assert rst_n=0 for one cycle while both stages are full → next cycle rsp_valid=0, busy=0, rsp_prod=0; no stale response appears afterwards.

Source files
------------

// File: rtl/mul4su_share_arb.sv
// Round-robin share of one 4x4 signed x unsigned multiplier among NREQ requesters; 2-cycle latency.
// Issue (A) and response (B) registers: rsp_ready=0 freezes B, A takes one more entry, then req_ready drops.
module mul4su_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_s,
  input  logic [4*NREQ-1:0] req_u,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_prod,
  output logic              busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [3:0]     op_s_q, op_s_d;
  logic [3:0]     op_u_q, op_u_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           a_valid_q, a_valid_d;
  logic [7:0]     rsp_prod_q, rsp_prod_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           b_ready, a_ready, arb_en;
  logic           gnt_found;
  logic [3:0]     gnt_s, gnt_u;
  logic [IDW-1:0] gnt_id;
  logic [7:0]     s_ext, u_ext, product;

  assign b_ready = !rsp_valid_q || rsp_ready;
  assign a_ready = !a_valid_q || b_ready;
  // No grant may be offered while reset is asserted, whatever the pipeline held.
  assign arb_en  = rst_n && a_ready;

  // Pass 0 scans ptr..NREQ-1, pass 1 scans 0..ptr-1: rotating priority with constant indices.
  always_comb begin
    gnt_found = 1'b0;
    gnt_s     = '0;
    gnt_u     = '0;
    gnt_id    = '0;
    req_ready = '0;
    if (arb_en) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!gnt_found && req_valid[i] && ((p == 0) == (i >= int'(ptr_q)))) begin
            gnt_found    = 1'b1;
            gnt_s        = req_s[4*i +: 4];
            gnt_u        = req_u[4*i +: 4];
            gnt_id       = IDW'(i);
            req_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // Low 8 bits of the extended product are exact: the true result lies in -120..105.
  always_comb begin
    s_ext   = {{4{op_s_q[3]}}, op_s_q};
    u_ext   = {4'b0000, op_u_q};
    product = s_ext * u_ext;
  end

  always_comb begin
    ptr_d       = ptr_q;
    op_s_d      = op_s_q;
    op_u_d      = op_u_q;
    op_id_d     = op_id_q;
    a_valid_d   = a_valid_q;
    rsp_prod_d  = rsp_prod_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;

    if (gnt_found) begin
      op_s_d    = gnt_s;
      op_u_d    = gnt_u;
      op_id_d   = gnt_id;
      a_valid_d = 1'b1;
      ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (b_ready) begin
      a_valid_d = 1'b0;
    end

    if (a_valid_q && b_ready) begin
      rsp_prod_d  = product;
      rsp_id_d    = op_id_q;
      rsp_valid_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      op_s_q      <= '0;
      op_u_q      <= '0;
      op_id_q     <= '0;
      a_valid_q   <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      op_s_q      <= op_s_d;
      op_u_q      <= op_u_d;
      op_id_q     <= op_id_d;
      a_valid_q   <= a_valid_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_prod  = rsp_prod_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = a_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_mul4su_share_arb.sv
// Bench for mul4su_share_arb: directed vectors, expected responses queued on acceptance, checked by a monitor.
module tb_mul4su_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_s;
  logic [15:0] req_u;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        busy;

  always #5 clk = ~clk;

  mul4su_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_s     (req_s),
    .req_u     (req_u),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic       hand_vld = 1'b0;
  logic [7:0] hand_exp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] s, input logic [3:0] u);
    int sv;
    sv = int'(s);
    if (s[3]) sv = sv - 16;
    return 8'(sv * int'(u));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acceptance monitor: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id   = 2'(i);
          e.prod = hand_vld ? hand_exp : model(req_s[4*i +: 4], req_u[4*i +: 4]);
          exp_q.push_back(e);
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d prod=%h expected none", rsp_id, rsp_prod);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_prod", 32'(rsp_prod), 32'(e.prod));
      end
    end
  end

  task automatic set_ops();
    req_s = {4'hA, 4'h6, 4'hF, 4'h8};
    req_u = {4'h3, 4'hE, 4'h7, 4'hB};
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic issue2(input logic [3:0] s, input logic [3:0] u,
                        input logic hv, input logic [7:0] he);
    int waited = 0;
    req_s[11:8] = s;
    req_u[11:8] = u;
    req_valid   = 4'b0100;
    hand_vld    = hv;
    hand_exp    = he;
    @(negedge clk);
    while (!req_ready[2] && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!req_ready[2]) check("issue2_grant", 32'(req_ready[2]), 32'd1);
    tick();
  endtask

  typedef struct {
    logic [3:0] s;
    logic [3:0] u;
    logic [7:0] p;
  } hand_t;

  hand_t hand_tab[10] = '{
    '{4'h8, 4'hF, 8'h88}, '{4'h7, 4'hF, 8'h69}, '{4'hF, 4'h1, 8'hFF},
    '{4'h0, 4'h9, 8'h00}, '{4'h3, 4'h5, 8'h0F}, '{4'hF, 4'hF, 8'hF1},
    '{4'h8, 4'h1, 8'hF8}, '{4'h1, 4'hF, 8'h0F}, '{4'h9, 4'h7, 8'hCF},
    '{4'h8, 4'h0, 8'h00}
  };

  initial begin
    int         acc;
    logic [3:0] oh;

    // Reset with a request already pending
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_s     = 16'h0007;
    req_u     = 16'h000F;
    tick();
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);

    // Single request 7 x 15 on requester 0
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("t1_busy_a", 32'(busy), 32'd1);
    check("t1_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_prod", 32'(rsp_prod), 32'h69);
    check("t1_id", 32'(rsp_id), 32'd0);
    tick();
    @(negedge clk);
    check("t1_busy_done", 32'(busy), 32'd0);

    // Full load: ptr is 1 after granting requester 0
    tick();
    set_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      oh = 4'b0001 << ((1 + k) % 4);
      check("rr_grant", 32'(req_ready), 32'(oh));
      if (k >= 2) check("rr_stream", 32'(rsp_valid), 32'd1);
      tick();
    end
    req_valid = 4'b0000;
    drain("rr_drain");

    // Hand-computed vectors, then the full sweep, through requester 2
    foreach (hand_tab[j]) issue2(hand_tab[j].s, hand_tab[j].u, 1'b1, hand_tab[j].p);
    for (int s = 0; s < 16; s++)
      for (int u = 0; u < 16; u++)
        issue2(4'(s), 4'(u), 1'b0, 8'h00);
    req_valid = 4'b0000;
    hand_vld  = 1'b0;
    drain("sweep_drain");

    // Backpressure under full load
    set_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) acc++;
      if (k >= 2) check("bp_ready_zero", 32'(req_ready), 32'd0);
      if (k >= 2) check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    check("bp_accepted", 32'(acc), 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 32'(|req_ready), 32'd1);
    tick();
    repeat (3) tick();
    req_valid = 4'b0000;
    drain("bp_drain");

    // Requester 1 last granted, then 0 and 3 compete
    req_valid = 4'b0010;
    @(negedge clk);
    check("wrap_r1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    check("wrap_r3_first", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    check("wrap_r0_next", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    drain("wrap_drain");

    // Reset while both stages are full
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    check("full_ready_zero", 32'(req_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_prod", 32'(rsp_prod), 32'd0);
    repeat (4) tick();
    req_valid = 4'b1111;
    @(negedge clk);
    check("ptr_after_reset", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
